led_share_arbiter: RTL

- Round-robin arbiter that shares the board RGB LED between NREQ requesters.
- The granted requester's colour drives the active-low LED pins.
- Each grant is held for a minimum dwell time. A grant is pre-empted after a maximum hold time, but only when another requester is waiting.
- Between owners the LED is forced dark for a gap period so each owner's colour is visibly distinct. Sits directly in front of the o_led_r/g/b board pins.

---
 rtl/led_share_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/led_share_arbiter.sv
// Round-robin arbiter that shares one active-low RGB LED between NREQ requesters.
// Each grant is held for at least MIN_DWELL cycles. A grant is revoked after MAX_HOLD
// cycles only if another requester is waiting. The LED is forced dark for GAP cycles
// between owners, plus the IDLE arbitration cycle.
module led_share_arbiter #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned MIN_DWELL = 4,
  parameter int unsigned MAX_HOLD  = 16,
  parameter int unsigned GAP       = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NREQ-1:0]     i_req,
  input  logic [3*NREQ-1:0]   i_colour,
  output logic [NREQ-1:0]     o_gnt,
  output logic                o_busy,
  output logic                o_led_r,
  output logic                o_led_g,
  output logic                o_led_b
);

  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
  localparam int unsigned PtrW = $clog2(NREQ);
  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [CntW-1:0] DwellLast = CntW'(MIN_DWELL - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(MAX_HOLD - 1);
  localparam logic [GapW-1:0] GapLast   = GapW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [PtrW-1:0] PtrMax    = PtrW'(NREQ - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic [2:0]      led_q, led_d;  // {r,g,b}, active-low

  logic [2:0]      colour [NREQ];
  logic            pick_valid;
  logic [PtrW-1:0] pick_idx;
  logic            other_req;
  logic            exit_grant;

  // Unpack the per-requester {r,g,b} colour fields.
  for (genvar n = 0; n < NREQ; n++) begin : g_colour
    assign colour[n] = i_colour[3*n +: 3];
  end

  // Pick the first active request at or after the round-robin pointer, wrapping around.
  always_comb begin
    int unsigned     sum;
    logic [PtrW-1:0] pidx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    sum        = 0;
    pidx       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sum  = 32'(ptr_q) + i;
      pidx = PtrW'((sum >= NREQ) ? sum - NREQ : sum);
      if (!pick_valid && i_req[pidx]) begin
        pick_valid = 1'b1;
        pick_idx   = pidx;
      end
    end
  end

  // Grant exit: owner released after its minimum dwell, or pre-empted at max hold
  // when someone else is waiting.
  always_comb begin
    other_req  = |(i_req & ~gnt_q);
    exit_grant = (!i_req[owner_q] && (cnt_q >= DwellLast)) ||
                 ((cnt_q >= HoldLast) && other_req);
  end

  // Next-state and registered-output logic for the IDLE / GRANT / GAP sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    gnt_d   = gnt_q;
    led_d   = led_q;
    unique case (state_q)
      StIdle: begin
        gnt_d = '0;
        led_d = '1;
        cnt_d = '0;
        if (pick_valid) begin
          state_d = StGrant;
          owner_d = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
          led_d   = ~colour[pick_idx];
        end
      end
      StGrant: begin
        if (exit_grant) begin
          // Advancing past the owner makes it lowest priority next time.
          ptr_d   = (owner_q == PtrMax) ? '0 : owner_q + 1'b1;
          gnt_d   = '0;
          led_d   = '1;
          cnt_d   = '0;
          gap_d   = '0;
          state_d = (GAP > 0) ? StGap : StIdle;
        end else begin
          if (cnt_q < HoldLast) begin
            cnt_d = cnt_q + 1'b1;
          end
          led_d = ~colour[owner_q];
        end
      end
      StGap: begin
        gnt_d = '0;
        led_d = '1;
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        led_d   = '1;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      led_q   <= '1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  assign o_gnt   = gnt_q;
  assign o_busy  = busy_q;
  assign o_led_r = led_q[2];
  assign o_led_g = led_q[1];
  assign o_led_b = led_q[0];

endmodule
